nios2_debug_cmd_sysclk_decoder: RTL and testbench

//  System-clock half of the JTAG debug slave, parametrised. Synchronises the virtual-JTAG UDR/UIR strobes,

---
 rtl/nios2_debug_pkg.sv | 14 +
 rtl/nios2_debug_sync_edge.sv | 27 ++
 rtl/nios2_debug_cmd_sysclk_decoder.sv | 151 +++++++++++++++
 tb/tb_nios2_debug_cmd_sysclk_decoder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_debug_pkg.sv
// Shared types and default widths for the Nios II JTAG debug slave, system-clock side.
package nios2_debug_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StIssue   = 2'd2
    } state_e;

    localparam int unsigned DefSrW    = 38;
    localparam int unsigned DefIrW    = 2;
    localparam int unsigned DefActBit = 35;

endpackage

// File: rtl/nios2_debug_sync_edge.sv
// Multi-flop synchroniser for a tck-domain level, with a one-cycle rising-edge pulse output.
module nios2_debug_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the async level through the chain and remember the last synced value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/nios2_debug_cmd_sysclk_decoder.sv
// System-clock half of the JTAG debug slave: captures jdo/IR on update-DR and issues
// per-channel take_action / take_no_action commands with ack, timeout and error flags.
module nios2_debug_cmd_sysclk_decoder
    import nios2_debug_pkg::*;
#(
    parameter int unsigned SR_W        = DefSrW,
    parameter int unsigned IR_W        = DefIrW,
    parameter int unsigned NCH         = 4,
    parameter int unsigned ACT_BIT     = DefActBit,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PULSE_MODE  = 0,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            vs_udr_i,
    input  logic            vs_uir_i,
    input  logic [IR_W-1:0] ir_in_i,
    input  logic [SR_W-1:0] sr_i,
    input  logic [NCH-1:0]  cmd_ack_i,
    input  logic            err_clr_i,
    output logic [SR_W-1:0] jdo_o,
    output logic [NCH-1:0]  take_action_o,
    output logic [NCH-1:0]  take_no_action_o,
    output logic            busy_o,
    output logic            err_overrun_o,
    output logic            err_timeout_o,
    output logic            err_bad_ir_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic            udr_p;
    logic            uir_p;
    state_e          state_q;
    logic [SR_W-1:0] jdo_q;
    logic [IR_W-1:0] ir_q;
    logic [NCH-1:0]  act_q;
    logic [NCH-1:0]  noact_q;
    logic [CntW-1:0] cnt_q;
    logic            ovr_q;
    logic            tmo_q;
    logic            bad_q;

    logic            ir_ok;
    logic [NCH-1:0]  ch_sel;
    logic            ack_hit;
    logic            timeout_hit;

    nios2_debug_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_udr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (vs_udr_i),
        .pulse_o (udr_p)
    );

    nios2_debug_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_uir (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (vs_uir_i),
        .pulse_o (uir_p)
    );

    assign ir_ok       = (32'(ir_q) < NCH);
    assign ch_sel      = NCH'(1) << ir_q;
    // Only the ack of the channel currently being driven counts.
    assign ack_hit     = |(cmd_ack_i & (act_q | noact_q));
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYC - 1));

    // Decoder FSM with registered command outputs, timeout counter and sticky flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            jdo_q   <= '0;
            ir_q    <= '0;
            act_q   <= '0;
            noact_q <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A same-cycle uir pulse is deliberately ignored here.
                    if (udr_p) begin
                        jdo_q   <= sr_i;
                        ir_q    <= ir_in_i;
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    if (uir_p) begin
                        state_q <= StIdle;
                    end else if (ir_ok) begin
                        act_q   <= jdo_q[ACT_BIT] ? ch_sel : '0;
                        noact_q <= jdo_q[ACT_BIT] ? '0 : ch_sel;
                        cnt_q   <= '0;
                        state_q <= StIssue;
                    end else begin
                        bad_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StIssue: begin
                    if (PULSE_MODE != 0 || uir_p || ack_hit) begin
                        act_q   <= '0;
                        noact_q <= '0;
                        state_q <= StIdle;
                    end else if (timeout_hit) begin
                        act_q   <= '0;
                        noact_q <= '0;
                        tmo_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    act_q   <= '0;
                    noact_q <= '0;
                    state_q <= StIdle;
                end
            endcase

            if (udr_p && state_q != StIdle) begin
                ovr_q <= 1'b1;
            end

            // Placed last so a clear overrides any set in the same cycle.
            if (err_clr_i) begin
                ovr_q <= 1'b0;
                tmo_q <= 1'b0;
                bad_q <= 1'b0;
            end
        end
    end

    assign jdo_o            = jdo_q;
    assign take_action_o    = act_q;
    assign take_no_action_o = noact_q;
    assign busy_o           = (state_q != StIdle);
    assign err_overrun_o    = ovr_q;
    assign err_timeout_o    = tmo_q;
    assign err_bad_ir_o     = bad_q;

endmodule

// File: tb/tb_nios2_debug_cmd_sysclk_decoder.sv
// Bench: a pulse-mode DUT (NCH=4) driven from a vector table, and an ack-mode DUT
// (NCH=3, TIMEOUT_CYC=8) driven by hand sequences. Issued commands are checked by scoreboards.
module tb_nios2_debug_cmd_sysclk_decoder;

    typedef struct packed {
        logic [37:0] sr;
        logic [3:0]  act;
        logic [3:0]  noact;
    } exp_t;

    typedef struct packed {
        logic [37:0] sr;
        logic [1:0]  ir;
        logic [3:0]  act;
        logic [3:0]  noact;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_clr = 1'b0;

    // Pulse-mode DUT signals
    logic        p_udr = 1'b0, p_uir = 1'b0;
    logic [1:0]  p_ir = '0;
    logic [37:0] p_sr = '0;
    logic [3:0]  p_ack = '0;
    logic [37:0] p_jdo;
    logic [3:0]  p_act, p_noact;
    logic        p_busy, p_ovr, p_tmo, p_bad;

    // Ack-mode DUT signals
    logic        l_udr = 1'b0, l_uir = 1'b0;
    logic [1:0]  l_ir = '0;
    logic [37:0] l_sr = '0;
    logic [2:0]  l_ack = '0;
    logic [37:0] l_jdo;
    logic [2:0]  l_act, l_noact;
    logic        l_busy, l_ovr, l_tmo, l_bad;

    int n_cmp = 0;
    int n_err = 0;
    exp_t q_p[$];
    exp_t q_l[$];
    vec_t vecs[4];
    logic l_prev = 1'b0;

    always #5 clk = ~clk;

    nios2_debug_cmd_sysclk_decoder #(
        .NCH (4), .PULSE_MODE (1)
    ) dut_p (
        .clk_i (clk), .rst_i (rst), .vs_udr_i (p_udr), .vs_uir_i (p_uir), .ir_in_i (p_ir),
        .sr_i (p_sr), .cmd_ack_i (p_ack), .err_clr_i (err_clr), .jdo_o (p_jdo),
        .take_action_o (p_act), .take_no_action_o (p_noact), .busy_o (p_busy),
        .err_overrun_o (p_ovr), .err_timeout_o (p_tmo), .err_bad_ir_o (p_bad)
    );

    nios2_debug_cmd_sysclk_decoder #(
        .NCH (3), .PULSE_MODE (0), .TIMEOUT_CYC (8)
    ) dut_l (
        .clk_i (clk), .rst_i (rst), .vs_udr_i (l_udr), .vs_uir_i (l_uir), .ir_in_i (l_ir),
        .sr_i (l_sr), .cmd_ack_i (l_ack), .err_clr_i (err_clr), .jdo_o (l_jdo),
        .take_action_o (l_act), .take_no_action_o (l_noact), .busy_o (l_busy),
        .err_overrun_o (l_ovr), .err_timeout_o (l_tmo), .err_bad_ir_o (l_bad)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds update-DR high for three edges (capture happens at the third), then low.
    task automatic udr_p_seq(input logic [37:0] s, input logic [1:0] ir);
        p_sr = s; p_ir = ir; p_udr = 1'b1;
        repeat (3) tick();
        p_udr = 1'b0;
        repeat (2) tick();
    endtask

    task automatic udr_l_seq(input logic [37:0] s, input logic [1:0] ir);
        l_sr = s; l_ir = ir; l_udr = 1'b1;
        repeat (3) tick();
        l_udr = 1'b0;
        repeat (2) tick();
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    // Pulse-mode scoreboard: every cycle with a command high consumes one expectation,
    // so a command wider than one cycle shows up as an unexpected extra.
    always @(negedge clk) begin
        if ((p_act | p_noact) != 4'b0) begin
            if (q_p.size() == 0) begin
                check("p_unexpected_cmd", {p_act, p_noact}, 8'h0);
            end else begin
                exp_t e;
                e = q_p.pop_front();
                check("p_take_action", p_act, e.act);
                check("p_take_no_action", p_noact, e.noact);
                check("p_jdo_at_cmd", p_jdo, e.sr);
            end
        end
    end

    // Ack-mode scoreboard: one expectation per rising command.
    always @(negedge clk) begin
        logic cur;
        cur = ((l_act | l_noact) != 3'b0);
        if (cur && !l_prev) begin
            if (q_l.size() == 0) begin
                check("l_unexpected_cmd", {l_act, l_noact}, 6'h0);
            end else begin
                exp_t e;
                e = q_l.pop_front();
                check("l_take_action", {1'b0, l_act}, e.act);
                check("l_take_no_action", {1'b0, l_noact}, e.noact);
                check("l_jdo_at_cmd", l_jdo, e.sr);
            end
        end
        l_prev = cur;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{sr: 38'h00_0000_0001, ir: 2'd0, act: 4'b0000, noact: 4'b0001};
        vecs[1] = '{sr: 38'h3F_FFFF_FFFF, ir: 2'd3, act: 4'b1000, noact: 4'b0000};
        vecs[2] = '{sr: 38'h37_FFFF_FFFF, ir: 2'd1, act: 4'b0000, noact: 4'b0010};
        vecs[3] = '{sr: 38'h08_0000_0000, ir: 2'd2, act: 4'b0100, noact: 4'b0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_p_outputs", {p_jdo, p_act, p_noact, p_busy, p_ovr, p_tmo, p_bad}, 64'h0);
        check("rst_l_outputs", {l_jdo, l_act, l_noact, l_busy, l_ovr, l_tmo, l_bad}, 64'h0);
        rst = 1'b0;
        tick();

        // Test 1: latency of jdo and the one-cycle take_action pulse
        p_sr = 38'h08_1234_5678; p_ir = 2'd2;
        q_p.push_back('{sr: 38'h08_1234_5678, act: 4'b0100, noact: 4'b0000});
        p_udr = 1'b1;
        tick();
        check("t1_jdo_edge0", p_jdo, 38'h0);
        tick();
        check("t1_jdo_edge1", p_jdo, 38'h0);
        tick();
        check("t1_jdo_edge2", p_jdo, 38'h08_1234_5678);
        check("t1_take_edge2", {p_act, p_noact}, 8'h00);
        check("t1_busy_edge2", p_busy, 1'b1);
        p_udr = 1'b0;
        tick();
        check("t1_take_edge3", {p_act, p_noact}, {4'b0100, 4'b0000});
        tick();
        check("t1_take_edge4", {p_act, p_noact}, 8'h00);
        check("t1_busy_edge4", p_busy, 1'b0);
        tick();

        // Pulse-mode vector table
        for (int i = 0; i < 4; i++) begin
            q_p.push_back('{sr: vecs[i].sr, act: vecs[i].act, noact: vecs[i].noact});
            udr_p_seq(vecs[i].sr, vecs[i].ir);
            tick();
            check("tbl_jdo_after", p_jdo, vecs[i].sr);
            check("tbl_busy_after", p_busy, 1'b0);
        end

        // Test 2: level held until ack on its own channel
        q_l.push_back('{sr: 38'h00_0000_00AB, act: 4'b0000, noact: 4'b0010});
        udr_l_seq(38'h00_0000_00AB, 2'd1);
        check("t2_held_a", {l_act, l_noact, l_busy}, {3'b000, 3'b010, 1'b1});
        l_ack = 3'b001;
        tick();
        check("t2_other_ack_ignored", {l_act, l_noact, l_busy}, {3'b000, 3'b010, 1'b1});
        l_ack = 3'b000;
        repeat (2) tick();
        check("t2_held_b", {l_act, l_noact}, {3'b000, 3'b010});
        l_ack = 3'b010;
        tick();
        l_ack = 3'b000;
        check("t2_dropped", {l_act, l_noact, l_busy}, 7'h0);
        check("t2_no_timeout", l_tmo, 1'b0);
        tick();

        // Test 3: timeout after 8 ISSUE cycles
        begin
            int n;
            q_l.push_back('{sr: 38'h08_0000_0003, act: 4'b0001, noact: 4'b0000});
            udr_l_seq(38'h08_0000_0003, 2'd0);
            n = 1; // the command was already high one sample before the task returned
            for (int i = 0; i < 20; i++) begin
                if (l_act == 3'b000) break;
                n++;
                tick();
            end
            check("t3_high_cycles", n, 8);
            check("t3_err_timeout", l_tmo, 1'b1);
            check("t3_busy", l_busy, 1'b0);
            clear_errs();
            check("t3_err_clr", l_tmo, 1'b0);
        end

        // Test 4: second udr during ISSUE flags overrun and is dropped
        q_l.push_back('{sr: 38'h08_AAAA_AAAA, act: 4'b0100, noact: 4'b0000});
        udr_l_seq(38'h08_AAAA_AAAA, 2'd2);
        udr_l_seq(38'h00_5555_5555, 2'd0);
        check("t4_err_overrun", l_ovr, 1'b1);
        check("t4_jdo_kept", l_jdo, 38'h08_AAAA_AAAA);
        check("t4_still_issuing", l_act, 3'b100);
        l_ack = 3'b100;
        tick();
        l_ack = 3'b000;
        repeat (4) tick();
        check("t4_idle", {l_act, l_noact, l_busy, l_tmo}, 8'h0);
        clear_errs();
        check("t4_err_clr", l_ovr, 1'b0);

        // Test 5a: IR out of range
        udr_l_seq(38'h08_0000_0000, 2'd3);
        check("t5_err_bad_ir", l_bad, 1'b1);
        check("t5_no_cmd", {l_act, l_noact, l_busy}, 7'h0);
        clear_errs();
        check("t5_bad_clr", l_bad, 1'b0);

        // Test 5b: uir in IDLE has no effect
        l_uir = 1'b1;
        repeat (3) tick();
        l_uir = 1'b0;
        repeat (2) tick();
        check("t5_uir_idle", {l_busy, l_ovr, l_tmo, l_bad}, 4'h0);

        // Test 5c: uir during ISSUE aborts without flags
        q_l.push_back('{sr: 38'h00_0000_0007, act: 4'b0000, noact: 4'b0001});
        udr_l_seq(38'h00_0000_0007, 2'd0);
        l_uir = 1'b1;
        repeat (3) tick();
        check("t5_abort_drop", {l_act, l_noact, l_busy}, 7'h0);
        l_uir = 1'b0;
        repeat (2) tick();
        check("t5_abort_flags", {l_ovr, l_tmo, l_bad}, 3'h0);

        // Test 5d: udr and uir together in IDLE - capture wins
        q_l.push_back('{sr: 38'h08_0000_0011, act: 4'b0010, noact: 4'b0000});
        l_sr = 38'h08_0000_0011; l_ir = 2'd1; l_udr = 1'b1; l_uir = 1'b1;
        repeat (3) tick();
        l_udr = 1'b0; l_uir = 1'b0;
        repeat (2) tick();
        check("t5_same_cycle_issue", {l_act, l_busy}, {3'b010, 1'b1});
        l_ack = 3'b010;
        tick();
        l_ack = 3'b000;
        check("t5_same_cycle_done", l_busy, 1'b0);
        tick();

        // Test 6: asynchronous reset mid-ISSUE, then a normal command
        q_l.push_back('{sr: 38'h08_0000_0022, act: 4'b0100, noact: 4'b0000});
        udr_l_seq(38'h08_0000_0022, 2'd2);
        check("t6_issuing", l_act, 3'b100);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_clear", {l_jdo, l_act, l_noact, l_busy}, 64'h0);
        tick();
        rst = 1'b0;
        tick();
        q_l.push_back('{sr: 38'h00_0000_0033, act: 4'b0000, noact: 4'b0010});
        udr_l_seq(38'h00_0000_0033, 2'd1);
        check("t6_post_reset_cmd", {l_noact, l_busy}, {3'b010, 1'b1});
        check("t6_post_reset_jdo", l_jdo, 38'h00_0000_0033);
        l_ack = 3'b010;
        tick();
        l_ack = 3'b000;
        check("t6_post_reset_done", l_busy, 1'b0);
        repeat (3) tick();

        check("p_queue_drained", q_p.size(), 0);
        check("l_queue_drained", q_l.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
